reg_writeback_queue: RTL and testbench

// - Writeback stage directly upstream of the 32-entry register file write port.
// - Merges register writes from the execute (ALU) and memory (load) units and buffers them in a small in-order FIFO.
// - Drains one write per cycle to the register file.
// - Forwards not-yet-written values to the three register-file read ports so decode never sees stale data.

---
 rtl/reg_wb_pkg.sv | 15 +
 rtl/reg_writeback_queue_if.sv | 68 ++++++
 rtl/wb_fwd_lookup.sv | 40 ++++
 rtl/reg_writeback_queue.sv | 132 +++++++++++++
 tb/tb_reg_writeback_queue.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/reg_wb_pkg.sv
// Shared types and constants for the register writeback queue.
// - REG_IDX_W       : width of a register index (32-entry register file).
// - DATA_SZ_DEFAULT : default MSB index of write data (buses are DATA_SZ_DEFAULT+1 bits).
// - wb_entry_t      : one queued register write (destination + data).
package reg_wb_pkg;

  localparam int unsigned REG_IDX_W       = 5;
  localparam int unsigned DATA_SZ_DEFAULT = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0]   rsel;
    logic [DATA_SZ_DEFAULT:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_queue_if.sv
// Bus bundle for reg_writeback_queue.
// Groups the mem/exec request handshakes, the register-file write port, the three
// forwarding lookups and the occupancy count.
// Modports:
// - slave  : the queue (drives out_*, samples in_*).
// - master : the surrounding pipeline / register file side.
interface reg_writeback_queue_if
  import reg_wb_pkg::*;
#(
  parameter int unsigned DataSz = DATA_SZ_DEFAULT,
  parameter int unsigned DEPTH  = 4
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  // Load unit request
  logic                 in_mem_valid;
  logic [REG_IDX_W-1:0] in_mem_reg;
  logic [DataSz:0]      in_mem_data;
  logic                 out_mem_ready;

  // ALU request
  logic                 in_exec_valid;
  logic [REG_IDX_W-1:0] in_exec_reg;
  logic [DataSz:0]      in_exec_data;
  logic                 out_exec_ready;

  // Register file write port
  logic                 out_write_enable;
  logic [REG_IDX_W-1:0] out_write_register_select;
  logic [DataSz:0]      out_write_data;

  // Forwarding for the three read ports
  logic [REG_IDX_W-1:0] in_read_register_select_0;
  logic [REG_IDX_W-1:0] in_read_register_select_1;
  logic [REG_IDX_W-1:0] in_read_register_select_2;
  logic                 out_fwd_hit_0;
  logic                 out_fwd_hit_1;
  logic                 out_fwd_hit_2;
  logic [DataSz:0]      out_fwd_data_0;
  logic [DataSz:0]      out_fwd_data_1;
  logic [DataSz:0]      out_fwd_data_2;

  logic [CntW-1:0]      out_count;

  modport slave (
    input  in_mem_valid, in_mem_reg, in_mem_data,
    input  in_exec_valid, in_exec_reg, in_exec_data,
    input  in_read_register_select_0, in_read_register_select_1, in_read_register_select_2,
    output out_mem_ready, out_exec_ready,
    output out_write_enable, out_write_register_select, out_write_data,
    output out_fwd_hit_0, out_fwd_hit_1, out_fwd_hit_2,
    output out_fwd_data_0, out_fwd_data_1, out_fwd_data_2,
    output out_count
  );

  modport master (
    output in_mem_valid, in_mem_reg, in_mem_data,
    output in_exec_valid, in_exec_reg, in_exec_data,
    output in_read_register_select_0, in_read_register_select_1, in_read_register_select_2,
    input  out_mem_ready, out_exec_ready,
    input  out_write_enable, out_write_register_select, out_write_data,
    input  out_fwd_hit_0, out_fwd_hit_1, out_fwd_hit_2,
    input  out_fwd_data_0, out_fwd_data_1, out_fwd_data_2,
    input  out_count
  );

endinterface

// File: rtl/wb_fwd_lookup.sv
// Youngest-match search over the occupied queue entries for one read port.
// Ports:
// - ent_rsel / ent_data : raw queue storage, indexed by physical slot.
// - head, count         : oldest slot and number of occupied slots.
// - sel                 : register being read.
// - hit, data           : a pending write to sel exists; its youngest value (0 when no hit).
module wb_fwd_lookup
  import reg_wb_pkg::*;
#(
  parameter int unsigned DataSz = DATA_SZ_DEFAULT,
  parameter int unsigned DEPTH  = 4
) (
  input  logic [REG_IDX_W-1:0]     ent_rsel [DEPTH],
  input  logic [DataSz:0]          ent_data [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [$clog2(DEPTH):0]   count,
  input  logic [REG_IDX_W-1:0]     sel,
  output logic                     hit,
  output logic [DataSz:0]          data
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PtrW'(i);
      if ((i < 32'(count)) && (sel != '0) && (ent_rsel[idx] == sel)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// In-order writeback FIFO in front of the register file write port.
// Ports:
// - CLK, RESET : clock and synchronous active-high reset.
// - bus        : reg_writeback_queue_if.slave carrying mem/exec requests, the write port,
//                the three forwarding lookups and out_count.
// Mem and exec writes are merged (mem older), one entry drains per cycle, and pending
// values are forwarded to the read ports so decode never sees stale register data.
module reg_writeback_queue
  import reg_wb_pkg::*;
#(
  parameter int unsigned DataSz = DATA_SZ_DEFAULT,
  parameter int unsigned DEPTH  = 4
) (
  input logic                   CLK,
  input logic                   RESET,
  reg_writeback_queue_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [PtrW-1:0] exec_slot;
  wb_entry_t       entries_q [DEPTH];

  logic [REG_IDX_W-1:0] ent_rsel [DEPTH];
  logic [DataSz:0]      ent_data [DEPTH];

  logic mem_ready, exec_ready;
  logic mem_push, exec_push;
  logic pop;

  // Readiness looks only at registered occupancy, never at this cycle's drain.
  // Exec yields the last free slot to mem, which is the older instruction.
  assign mem_ready  = !RESET && (count_q < CntW'(DEPTH));
  assign exec_ready = !RESET && ((count_q < CntW'(DEPTH - 1)) ||
                                 ((count_q == CntW'(DEPTH - 1)) && !bus.in_mem_valid));

  // Writes to x0 complete the handshake but are silently discarded.
  assign mem_push  = bus.in_mem_valid && mem_ready && (bus.in_mem_reg != '0);
  assign exec_push = bus.in_exec_valid && exec_ready && (bus.in_exec_reg != '0);
  assign pop       = !RESET && (count_q != '0);

  // Exec lands behind mem when both are enqueued together.
  assign exec_slot = tail_q + PtrW'(mem_push);

  always_comb begin
    count_d = count_q + CntW'(mem_push) + CntW'(exec_push) - CntW'(pop);
    head_d  = head_q + PtrW'(pop);
    tail_d  = tail_q + PtrW'(mem_push) + PtrW'(exec_push);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Storage needs no reset: slots are only observed while counted as occupied.
  always_ff @(posedge CLK) begin
    if (mem_push) begin
      entries_q[tail_q] <= '{rsel: bus.in_mem_reg, data: bus.in_mem_data};
    end
    if (exec_push) begin
      entries_q[exec_slot] <= '{rsel: bus.in_exec_reg, data: bus.in_exec_data};
    end
  end

  assign bus.out_mem_ready  = mem_ready;
  assign bus.out_exec_ready = exec_ready;
  assign bus.out_count      = count_q;

  // Write port: the head entry, zeroed when idle; suppressed while RESET discards the queue.
  assign bus.out_write_enable          = pop;
  assign bus.out_write_register_select = pop ? entries_q[head_q].rsel : '0;
  assign bus.out_write_data            = pop ? entries_q[head_q].data : '0;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_rsel[i] = entries_q[i].rsel;
      ent_data[i] = entries_q[i].data;
    end
  end

  wb_fwd_lookup #(
    .DataSz (DataSz),
    .DEPTH  (DEPTH)
  ) u_fwd_0 (
    .ent_rsel (ent_rsel),
    .ent_data (ent_data),
    .head     (head_q),
    .count    (count_q),
    .sel      (bus.in_read_register_select_0),
    .hit      (bus.out_fwd_hit_0),
    .data     (bus.out_fwd_data_0)
  );

  wb_fwd_lookup #(
    .DataSz (DataSz),
    .DEPTH  (DEPTH)
  ) u_fwd_1 (
    .ent_rsel (ent_rsel),
    .ent_data (ent_data),
    .head     (head_q),
    .count    (count_q),
    .sel      (bus.in_read_register_select_1),
    .hit      (bus.out_fwd_hit_1),
    .data     (bus.out_fwd_data_1)
  );

  wb_fwd_lookup #(
    .DataSz (DataSz),
    .DEPTH  (DEPTH)
  ) u_fwd_2 (
    .ent_rsel (ent_rsel),
    .ent_data (ent_data),
    .head     (head_q),
    .count    (count_q),
    .sel      (bus.in_read_register_select_2),
    .hit      (bus.out_fwd_hit_2),
    .data     (bus.out_fwd_data_2)
  );

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue (DataSz=32, DEPTH=4).
// A table of one-cycle vectors walks through single writes, same-register pairs,
// saturation and x0 discards; reset behaviour is exercised by hand-written sequences.
module tb_reg_writeback_queue;

  logic CLK;
  logic RESET;

  int n_tests;
  int n_fail;

  reg_writeback_queue_if #(.DataSz(32), .DEPTH(4)) bus ();

  reg_writeback_queue #(
    .DataSz (32),
    .DEPTH  (4)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        mv;
    logic [4:0]  mr;
    logic [32:0] md;
    logic        ev;
    logic [4:0]  er;
    logic [32:0] ed;
    logic [4:0]  sel;
    logic        e_mrdy;
    logic        e_erdy;
    logic        e_we;
    logic [4:0]  e_wsel;
    logic [32:0] e_wdata;
    logic        e_hit;
    logic [32:0] e_fdata;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic mv, input logic [4:0] mr, input logic [32:0] md,
                              input logic ev, input logic [4:0] er, input logic [32:0] ed,
                              input logic [4:0] sel, input logic e_mrdy, input logic e_erdy,
                              input logic e_we, input logic [4:0] e_wsel,
                              input logic [32:0] e_wdata, input logic e_hit,
                              input logic [32:0] e_fdata, input logic [2:0] e_cnt);
    vec_t v;
    v.mv = mv; v.mr = mr; v.md = md;
    v.ev = ev; v.er = er; v.ed = ed;
    v.sel = sel;
    v.e_mrdy = e_mrdy; v.e_erdy = e_erdy;
    v.e_we = e_we; v.e_wsel = e_wsel; v.e_wdata = e_wdata;
    v.e_hit = e_hit; v.e_fdata = e_fdata; v.e_cnt = e_cnt;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.in_mem_valid  = 1'b0;
    bus.in_mem_reg    = '0;
    bus.in_mem_data   = '0;
    bus.in_exec_valid = 1'b0;
    bus.in_exec_reg   = '0;
    bus.in_exec_data  = '0;
  endtask

  task automatic set_sel(input logic [4:0] s);
    bus.in_read_register_select_0 = s;
    bus.in_read_register_select_1 = s;
    bus.in_read_register_select_2 = s;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //        mv mr     md         ev er     ed         sel    mr er we wsel   wdata      hit fdata    cnt
    // single write
    add(1'b0, 5'd0, 33'h0,    1'b0, 5'd0, 33'h0,    5'd5, 1, 1, 0, 5'd0, 33'h0,    0, 33'h0,    3'd0);
    add(1'b0, 5'd0, 33'h0,    1'b1, 5'd5, 33'h1234, 5'd5, 1, 1, 0, 5'd0, 33'h0,    0, 33'h0,    3'd0);
    add(1'b0, 5'd0, 33'h0,    1'b0, 5'd0, 33'h0,    5'd5, 1, 1, 1, 5'd5, 33'h1234, 1, 33'h1234, 3'd1);
    add(1'b0, 5'd0, 33'h0,    1'b0, 5'd0, 33'h0,    5'd5, 1, 1, 0, 5'd0, 33'h0,    0, 33'h0,    3'd0);
    // same-register pair: mem older, exec value forwarded while both pending
    add(1'b1, 5'd3, 33'hA,    1'b1, 5'd3, 33'hB,    5'd3, 1, 1, 0, 5'd0, 33'h0,    0, 33'h0,    3'd0);
    add(1'b0, 5'd0, 33'h0,    1'b0, 5'd0, 33'h0,    5'd3, 1, 1, 1, 5'd3, 33'hA,    1, 33'hB,    3'd2);
    add(1'b0, 5'd0, 33'h0,    1'b0, 5'd0, 33'h0,    5'd3, 1, 1, 1, 5'd3, 33'hB,    1, 33'hB,    3'd1);
    add(1'b0, 5'd0, 33'h0,    1'b0, 5'd0, 33'h0,    5'd3, 1, 1, 0, 5'd0, 33'h0,    0, 33'h0,    3'd0);
    // saturation
    add(1'b1, 5'd1, 33'h11,   1'b1, 5'd2, 33'h22,   5'd2, 1, 1, 0, 5'd0, 33'h0,    0, 33'h0,    3'd0);
    add(1'b1, 5'd4, 33'h44,   1'b1, 5'd6, 33'h66,   5'd1, 1, 1, 1, 5'd1, 33'h11,   1, 33'h11,   3'd2);
    add(1'b1, 5'd7, 33'h77,   1'b1, 5'd8, 33'h88,   5'd6, 1, 0, 1, 5'd2, 33'h22,   1, 33'h66,   3'd3);
    add(1'b1, 5'd9, 33'h99,   1'b1, 5'd8, 33'h88,   5'd7, 1, 0, 1, 5'd4, 33'h44,   1, 33'h77,   3'd3);
    add(1'b0, 5'd0, 33'h0,    1'b1, 5'd8, 33'h88,   5'd8, 1, 1, 1, 5'd6, 33'h66,   0, 33'h0,    3'd3);
    add(1'b0, 5'd0, 33'h0,    1'b0, 5'd0, 33'h0,    5'd9, 1, 1, 1, 5'd7, 33'h77,   1, 33'h99,   3'd3);
    // x0 write handshakes but is discarded
    add(1'b0, 5'd0, 33'h0,    1'b1, 5'd0, 33'hFFFF, 5'd0, 1, 1, 1, 5'd9, 33'h99,   0, 33'h0,    3'd2);
    add(1'b0, 5'd0, 33'h0,    1'b0, 5'd0, 33'h0,    5'd0, 1, 1, 1, 5'd8, 33'h88,   0, 33'h0,    3'd1);
    add(1'b0, 5'd0, 33'h0,    1'b0, 5'd0, 33'h0,    5'd0, 1, 1, 0, 5'd0, 33'h0,    0, 33'h0,    3'd0);

    // Reset held two cycles with both sources requesting
    RESET = 1'b1;
    set_sel(5'd1);
    bus.in_mem_valid  = 1'b1; bus.in_mem_reg  = 5'd1; bus.in_mem_data  = 33'h5;
    bus.in_exec_valid = 1'b1; bus.in_exec_reg = 5'd2; bus.in_exec_data = 33'h6;
    #2;
    chk("rst0_mem_ready", 64'(bus.out_mem_ready), 64'd0);
    chk("rst0_exec_ready", 64'(bus.out_exec_ready), 64'd0);
    tick();
    chk("rst1_mem_ready", 64'(bus.out_mem_ready), 64'd0);
    chk("rst1_exec_ready", 64'(bus.out_exec_ready), 64'd0);
    chk("rst1_we", 64'(bus.out_write_enable), 64'd0);
    chk("rst1_count", 64'(bus.out_count), 64'd0);
    tick();
    RESET = 1'b0;
    idle();
    #1;
    chk("post_rst_count", 64'(bus.out_count), 64'd0);
    chk("post_rst_mem_ready", 64'(bus.out_mem_ready), 64'd1);
    chk("post_rst_exec_ready", 64'(bus.out_exec_ready), 64'd1);
    chk("post_rst_we", 64'(bus.out_write_enable), 64'd0);
    chk("post_rst_hit0", 64'(bus.out_fwd_hit_0), 64'd0);
    tick();

    // Table-driven vectors, one cycle each
    foreach (vq[i]) begin
      bus.in_mem_valid  = vq[i].mv;
      bus.in_mem_reg    = vq[i].mr;
      bus.in_mem_data   = vq[i].md;
      bus.in_exec_valid = vq[i].ev;
      bus.in_exec_reg   = vq[i].er;
      bus.in_exec_data  = vq[i].ed;
      set_sel(vq[i].sel);
      #2;
      chk($sformatf("v%0d_mem_ready", i), 64'(bus.out_mem_ready), 64'(vq[i].e_mrdy));
      chk($sformatf("v%0d_exec_ready", i), 64'(bus.out_exec_ready), 64'(vq[i].e_erdy));
      chk($sformatf("v%0d_we", i), 64'(bus.out_write_enable), 64'(vq[i].e_we));
      chk($sformatf("v%0d_wsel", i), 64'(bus.out_write_register_select), 64'(vq[i].e_wsel));
      chk($sformatf("v%0d_wdata", i), 64'(bus.out_write_data), 64'(vq[i].e_wdata));
      chk($sformatf("v%0d_count", i), 64'(bus.out_count), 64'(vq[i].e_cnt));
      chk($sformatf("v%0d_hit0", i), 64'(bus.out_fwd_hit_0), 64'(vq[i].e_hit));
      chk($sformatf("v%0d_hit1", i), 64'(bus.out_fwd_hit_1), 64'(vq[i].e_hit));
      chk($sformatf("v%0d_hit2", i), 64'(bus.out_fwd_hit_2), 64'(vq[i].e_hit));
      if (vq[i].e_hit) begin
        chk($sformatf("v%0d_fdata0", i), 64'(bus.out_fwd_data_0), 64'(vq[i].e_fdata));
        chk($sformatf("v%0d_fdata1", i), 64'(bus.out_fwd_data_1), 64'(vq[i].e_fdata));
        chk($sformatf("v%0d_fdata2", i), 64'(bus.out_fwd_data_2), 64'(vq[i].e_fdata));
      end
      tick();
    end

    // Reset mid-run with three entries queued
    idle();
    set_sel(5'd12);
    bus.in_mem_valid  = 1'b1; bus.in_mem_reg  = 5'd10; bus.in_mem_data  = 33'hA0;
    bus.in_exec_valid = 1'b1; bus.in_exec_reg = 5'd11; bus.in_exec_data = 33'hB0;
    tick();
    bus.in_mem_valid  = 1'b1; bus.in_mem_reg  = 5'd12; bus.in_mem_data  = 33'hC0;
    bus.in_exec_valid = 1'b1; bus.in_exec_reg = 5'd13; bus.in_exec_data = 33'hD0;
    #2;
    chk("mr_count_a", 64'(bus.out_count), 64'd2);
    chk("mr_wsel_a", 64'(bus.out_write_register_select), 64'd10);
    tick();
    idle();
    #2;
    chk("mr_count_b", 64'(bus.out_count), 64'd3);
    chk("mr_wsel_b", 64'(bus.out_write_register_select), 64'd11);
    chk("mr_hit_b", 64'(bus.out_fwd_hit_0), 64'd1);
    chk("mr_fdata_b", 64'(bus.out_fwd_data_0), 64'hC0);
    RESET = 1'b1;
    bus.in_mem_valid = 1'b1; bus.in_mem_reg = 5'd14; bus.in_mem_data = 33'hE0;
    #1;
    chk("mr_rst_mem_ready", 64'(bus.out_mem_ready), 64'd0);
    chk("mr_rst_exec_ready", 64'(bus.out_exec_ready), 64'd0);
    chk("mr_rst_we", 64'(bus.out_write_enable), 64'd0);
    tick();
    RESET = 1'b0;
    idle();
    #1;
    chk("mr_post_count", 64'(bus.out_count), 64'd0);
    chk("mr_post_hit", 64'(bus.out_fwd_hit_0), 64'd0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mr_drain%0d_we", k), 64'(bus.out_write_enable), 64'd0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
